qnet_time_base: RTL and testbench
=================================

QNET_TIME_BASE -- requirements
Module: qnet_time_base

Interface
REQ-001 Parameter: UPDT_CNT_W, default 16, width of the applied-update counter.
REQ-002 Parameter: SYNC_W, default 32, width of the sync period and phase counter.
REQ-003 One clock; reset is asynchronous and active-low: t_clk_i in 1, time clock.
REQ-004 t_rst_ni in 1, asynchronous active-low reset.
REQ-005 time_reset_i in 1, single-cycle pulse: clear time and stop.
REQ-006 time_init_i in 1, single-cycle pulse: load time_init_val_i and run.
REQ-007 time_updt_i in 1, single-cycle pulse: apply signed offset time_off_dt_i.
REQ-008 time_init_val_i in 48, time value loaded on init.
REQ-009 time_off_dt_i in 32, two's-complement offset, sign-extended to 48 bits.
REQ-010 sync_period_i in SYNC_W, sync period in clocks; 0 disables the sync pulse.
REQ-011 t_time_abs_o out 48, absolute time feeding the command stage.
REQ-012 time_run_o out 1, high while the counter advances.
REQ-013 updt_busy_o out 1, high while an offset update is in flight.
REQ-014 updt_cnt_o out UPDT_CNT_W, number of applied updates, saturating.
REQ-015 time_err_o out 1, sticky error flag.
REQ-016 net_sync_t01_o out 1, one-cycle periodic sync pulse.

Function
REQ-017 States: ST_STOP, ST_RUN, ST_UPDT1, ST_UPDT2; the block enters ST_STOP on reset.
REQ-018 ST_STOP: t_time_abs_o holds its value and time_run_o=0.
REQ-019 ST_RUN, ST_UPDT1, ST_UPDT2: t_time_abs_o increments by 1 per clock, modulo 2^48 (0xFFFF_FFFF_FFFF -> 0) with no flag on wrap.
REQ-020 Priority when inputs coincide in the same cycle: time_reset_i > time_init_i > time_updt_i; lower-priority pulses in that cycle are dropped without error.
REQ-021 time_reset_i, in any state: next cycle t_time_abs_o=0, state ST_STOP, an in-flight update is aborted, updt_cnt_o=0, time_err_o=0, sync phase=0.
REQ-022 time_init_i, in any state: next cycle t_time_abs_o=time_init_val_i, state ST_RUN, an in-flight update is aborted, sync phase=0; updt_cnt_o and time_err_o are unchanged.
REQ-023 time_updt_i in ST_RUN: the sign-extended offset is registered and the state moves to ST_UPDT1; updt_busy_o=1 in ST_UPDT1 and ST_UPDT2.
REQ-024 ST_UPDT1 -> ST_UPDT2 unconditionally: in ST_UPDT1, sum = t_time_abs + 2 + offset is computed, compensating the two clocks of pipeline.
REQ-025 ST_UPDT2: t_time_abs_o <= sum, updt_cnt_o increments (saturates at all-ones), state -> ST_RUN.
REQ-026 Net effect: the first post-update value equals the uncorrected value + offset; wrap is modulo 2^48.
REQ-027 time_updt_i in ST_STOP, ST_UPDT1 or ST_UPDT2 is ignored and sets time_err_o=1.
REQ-028 time_err_o clears only on reset or time_reset_i.
REQ-029 Outputs are registered; no combinational input-to-output paths.

Reset
REQ-030 While t_rst_ni=0: t_time_abs_o=0, time_run_o=0, updt_busy_o=0, updt_cnt_o=0, time_err_o=0, net_sync_t01_o=0, state ST_STOP, sync phase=0.
REQ-031 Reset assertion takes effect immediately and overrides any in-flight update.
REQ-032 After reset deassertion, the block does nothing until the first pulse input.

Configuration
REQ-033 Macro QNET_TIME_SYNC_EN, defined: phase counter active.
REQ-034 Phase counter behaviour: counts only while time_run_o=1 and sync_period_i!=0; when phase = sync_period_i-1, net_sync_t01_o=1 for one cycle and phase -> 0.
REQ-035 Phase counter clearing: phase is cleared on time_init_i and time_reset_i.
REQ-036 sync_period_i change: a change takes effect at the next comparison, and phase >= new period wraps to 0 on the following cycle.
REQ-037 Macro QNET_TIME_SYNC_EN, undefined: no phase counter logic; net_sync_t01_o is tied to 0 and sync_period_i is unused.

Verification
REQ-038 Reset, then time_init_i with val=100 -> t_time_abs_o=100 the next cycle, then 101, 102; time_run_o=1.
REQ-039 Running at T=1000 with time_updt_i offset=+50 -> updt_busy_o=1 for 2 cycles; the value after ST_UPDT2 is 1003+50=1053; updt_cnt_o=1.
REQ-040 Offset=0xFFFF_FFF6 (-10) -> the post-update value is 10 less than uncorrected; repeat the test with init val=0xFFFF_FFFF_FFFE to check 48-bit wrap to 0/1.
REQ-041 time_updt_i during ST_UPDT1 -> ignored and time_err_o=1; a following time_reset_i -> time_err_o=0, t_time_abs_o=0, time_run_o=0.
REQ-042 Coinciding pulses: time_init_i and time_updt_i in the same cycle -> only init is applied and time_err_o stays 0; time_reset_i and time_init_i in the same cycle -> ST_STOP, time=0.
REQ-043 With QNET_TIME_SYNC_EN, sync_period_i=8 after init -> net_sync_t01_o pulses every 8 clocks, the first pulse 8 cycles after init; with the macro undefined, it is always 0.

Source files
------------

// File: rtl/qnet_time_base.sv
// 48-bit absolute time base with pipelined signed offset correction.
// Optional periodic sync pulse generator enabled by defining QNET_TIME_SYNC_EN.
module qnet_time_base #(
    parameter int UPDT_CNT_W = 16,
    parameter int SYNC_W     = 32
) (
    input  logic                  t_clk_i,
    input  logic                  t_rst_ni,
    input  logic                  time_reset_i,
    input  logic                  time_init_i,
    input  logic                  time_updt_i,
    input  logic [47:0]           time_init_val_i,
    input  logic [31:0]           time_off_dt_i,
    input  logic [SYNC_W-1:0]     sync_period_i,
    output logic [47:0]           t_time_abs_o,
    output logic                  time_run_o,
    output logic                  updt_busy_o,
    output logic [UPDT_CNT_W-1:0] updt_cnt_o,
    output logic                  time_err_o,
    output logic                  net_sync_t01_o
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_UPDT1 = 2'd2,
        ST_UPDT2 = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [47:0] time_abs;
    logic [47:0] offset;
    logic [47:0] sum;
    logic [UPDT_CNT_W-1:0] updt_cnt;
    logic        time_err;

    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (time_reset_i) begin
            state_next = ST_STOP;
        end else if (time_init_i) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (time_updt_i) state_next = ST_UPDT1;
                ST_UPDT1: state_next = ST_UPDT2;
                ST_UPDT2: state_next = ST_RUN;
                default:  state_next = ST_STOP;
            endcase
        end
    end

    always_comb begin
        time_run_o  = (state != ST_STOP);
        updt_busy_o = (state == ST_UPDT1) || (state == ST_UPDT2);
    end

    // The sum is taken in UPDT1 and lands two clocks later, hence the +2.
    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            time_abs <= '0;
            offset   <= '0;
            sum      <= '0;
            updt_cnt <= '0;
            time_err <= 1'b0;
        end else if (time_reset_i) begin
            time_abs <= '0;
            updt_cnt <= '0;
            time_err <= 1'b0;
        end else if (time_init_i) begin
            time_abs <= time_init_val_i;
        end else begin
            if (state == ST_UPDT2) begin
                time_abs <= sum;
            end else if (state != ST_STOP) begin
                time_abs <= time_abs + 48'd1;
            end
            if (time_updt_i) begin
                if (state == ST_RUN) begin
                    offset <= {{16{time_off_dt_i[31]}}, time_off_dt_i};
                end else begin
                    time_err <= 1'b1;
                end
            end
            if (state == ST_UPDT1) begin
                sum <= time_abs + 48'd2 + offset;
            end
            if (state == ST_UPDT2 && updt_cnt != {UPDT_CNT_W{1'b1}}) begin
                updt_cnt <= updt_cnt + 1'b1;
            end
        end
    end

    assign t_time_abs_o = time_abs;
    assign updt_cnt_o   = updt_cnt;
    assign time_err_o   = time_err;

`ifdef QNET_TIME_SYNC_EN
    logic [SYNC_W-1:0] phase;
    logic              sync_pulse;

    // A phase left beyond a shortened period falls back to zero instead of pulsing.
    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            phase      <= '0;
            sync_pulse <= 1'b0;
        end else if (time_reset_i || time_init_i) begin
            phase      <= '0;
            sync_pulse <= 1'b0;
        end else if (time_run_o && sync_period_i != '0) begin
            if (phase == sync_period_i - 1'b1) begin
                phase      <= '0;
                sync_pulse <= 1'b1;
            end else if (phase >= sync_period_i) begin
                phase      <= '0;
                sync_pulse <= 1'b0;
            end else begin
                phase      <= phase + 1'b1;
                sync_pulse <= 1'b0;
            end
        end else begin
            sync_pulse <= 1'b0;
        end
    end

    assign net_sync_t01_o = sync_pulse;
`else
    logic unused_sync_period;
    assign unused_sync_period = ^sync_period_i;
    assign net_sync_t01_o     = 1'b0;
`endif

endmodule

// File: tb/tb_qnet_time_base.sv
// Self-checking bench for qnet_time_base: directed scenarios followed by
// randomized pulses compared against a cycle-level behavioural model.
module tb_qnet_time_base;

    logic        t_clk_i = 1'b0;
    logic        t_rst_ni;
    logic        time_reset_i;
    logic        time_init_i;
    logic        time_updt_i;
    logic [47:0] time_init_val_i;
    logic [31:0] time_off_dt_i;
    logic [31:0] sync_period_i;
    logic [47:0] t_time_abs_o;
    logic        time_run_o;
    logic        updt_busy_o;
    logic [15:0] updt_cnt_o;
    logic        time_err_o;
    logic        net_sync_t01_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: time, run flag, edges until a pending offset lands.
    logic [47:0] m_time;
    bit          m_run;
    int          m_left;
    logic [47:0] m_pend;
    logic [15:0] m_cnt;
    bit          m_err;
    logic [31:0] m_phase;
    bit          m_sync;

    qnet_time_base dut (
        .t_clk_i         (t_clk_i),
        .t_rst_ni        (t_rst_ni),
        .time_reset_i    (time_reset_i),
        .time_init_i     (time_init_i),
        .time_updt_i     (time_updt_i),
        .time_init_val_i (time_init_val_i),
        .time_off_dt_i   (time_off_dt_i),
        .sync_period_i   (sync_period_i),
        .t_time_abs_o    (t_time_abs_o),
        .time_run_o      (time_run_o),
        .updt_busy_o     (updt_busy_o),
        .updt_cnt_o      (updt_cnt_o),
        .time_err_o      (time_err_o),
        .net_sync_t01_o  (net_sync_t01_o)
    );

    always #5 t_clk_i = ~t_clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit i, input bit u,
                              input logic [47:0] v, input logic [31:0] o);
        bit was_run;
        bit accept;
        was_run = m_run;
        accept  = m_run && (m_left == 0);
        if (r) begin
            m_time = '0; m_run = 0; m_left = 0; m_cnt = '0; m_err = 0;
            m_phase = '0; m_sync = 0;
        end else if (i) begin
            m_time = v; m_run = 1; m_left = 0; m_phase = '0; m_sync = 0;
        end else begin
            m_sync = 0;
`ifdef QNET_TIME_SYNC_EN
            if (was_run && sync_period_i != 0) begin
                if (m_phase + 1 == sync_period_i) begin
                    m_sync = 1; m_phase = '0;
                end else if (m_phase >= sync_period_i) begin
                    m_phase = '0;
                end else begin
                    m_phase = m_phase + 1;
                end
            end
`endif
            if (m_left == 1) begin
                m_time = m_time + 48'd1 + m_pend;
                m_left = 0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else if (m_run) begin
                m_time = m_time + 48'd1;
                if (m_left == 2) m_left = 1;
            end
            if (u) begin
                if (accept) begin
                    m_pend = {{16{o[31]}}, o};
                    m_left = 2;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, ".time"}, {16'h0, t_time_abs_o}, {16'h0, m_time});
        check({tag, ".run"},  {63'h0, time_run_o},   {63'h0, m_run});
        check({tag, ".busy"}, {63'h0, updt_busy_o},  {63'h0, (m_left != 0)});
        check({tag, ".cnt"},  {48'h0, updt_cnt_o},   {48'h0, m_cnt});
        check({tag, ".err"},  {63'h0, time_err_o},   {63'h0, m_err});
        check({tag, ".sync"}, {63'h0, net_sync_t01_o}, {63'h0, m_sync});
    endtask

    task automatic apply_stimulus(input bit r, input bit i, input bit u,
                                  input logic [47:0] v, input logic [31:0] o);
        @(negedge t_clk_i);
        time_reset_i    = r;
        time_init_i     = i;
        time_updt_i     = u;
        time_init_val_i = v;
        time_off_dt_i   = o;
        @(posedge t_clk_i);
        model_edge(r, i, u, v, o);
        #1;
        time_reset_i = 0;
        time_init_i  = 0;
        time_updt_i  = 0;
        check_output("step");
    endtask

    task automatic idle();
        apply_stimulus(0, 0, 0, 48'h0, 32'h0);
    endtask

    task automatic async_reset();
        @(negedge t_clk_i);
        #2;
        t_rst_ni = 0;
        #1;
        model_edge(1, 0, 0, 48'h0, 32'h0);
        check_output("arst");
        @(posedge t_clk_i);
        #1;
        check_output("arst_hold");
        @(negedge t_clk_i);
        t_rst_ni = 1;
    endtask

    initial begin
        bit          r, i, u;
        logic [47:0] v;
        logic [31:0] o;
        bit          exp_sync;

        t_rst_ni        = 0;
        time_reset_i    = 0;
        time_init_i     = 0;
        time_updt_i     = 0;
        time_init_val_i = '0;
        time_off_dt_i   = '0;
        sync_period_i   = '0;
        m_pend          = '0;
        model_edge(1, 0, 0, 48'h0, 32'h0);
        #12;
        check_output("reset");
        @(negedge t_clk_i);
        t_rst_ni = 1;
        idle();
        check("idle_after_reset", {16'h0, t_time_abs_o}, 64'd0);

        // Init to 100 and run
        apply_stimulus(0, 1, 0, 48'd100, 32'h0);
        check("init100", {16'h0, t_time_abs_o}, 64'd100);
        idle();
        check("init101", {16'h0, t_time_abs_o}, 64'd101);
        idle();
        check("init102", {16'h0, t_time_abs_o}, 64'd102);
        check("init_run", {63'h0, time_run_o}, 64'd1);

        // +50 update issued while time reads 1000
        apply_stimulus(0, 1, 0, 48'd997, 32'h0);
        repeat (3) idle();
        apply_stimulus(0, 0, 1, 48'h0, 32'd50);
        check("upd_busy1", {63'h0, updt_busy_o}, 64'd1);
        idle();
        check("upd_busy2", {63'h0, updt_busy_o}, 64'd1);
        idle();
        check("upd_val", {16'h0, t_time_abs_o}, 64'd1053);
        check("upd_cnt", {48'h0, updt_cnt_o}, 64'd1);
        check("upd_done", {63'h0, updt_busy_o}, 64'd0);

        // Negative offset across the 48-bit wrap
        apply_stimulus(0, 1, 0, 48'hFFFF_FFFF_FFFE, 32'h0);
        idle();
        check("wrap_ff", {16'h0, t_time_abs_o}, 64'hFFFF_FFFF_FFFF);
        idle();
        check("wrap_0", {16'h0, t_time_abs_o}, 64'd0);
        idle();
        check("wrap_1", {16'h0, t_time_abs_o}, 64'd1);
        apply_stimulus(0, 0, 1, 48'h0, 32'hFFFF_FFF6);
        repeat (2) idle();
        check("neg_off", {16'h0, t_time_abs_o}, 64'hFFFF_FFFF_FFFA);
        apply_stimulus(0, 1, 1, 48'hFFFF_FFFF_FFFE, 32'd5);
        apply_stimulus(0, 0, 1, 48'h0, 32'd5);
        repeat (2) idle();
        check("wrap_pos_off", {16'h0, t_time_abs_o}, 64'd6);

        // Update during UPDT1 is an error; time_reset clears it
        apply_stimulus(0, 0, 1, 48'h0, 32'd7);
        apply_stimulus(0, 0, 1, 48'h0, 32'd9);
        check("err_set", {63'h0, time_err_o}, 64'd1);
        idle();
        apply_stimulus(1, 0, 0, 48'h0, 32'h0);
        check("err_clr", {63'h0, time_err_o}, 64'd0);
        check("rst_time", {16'h0, t_time_abs_o}, 64'd0);
        check("rst_run", {63'h0, time_run_o}, 64'd0);
        apply_stimulus(0, 0, 1, 48'h0, 32'd1);
        check("stop_updt_err", {63'h0, time_err_o}, 64'd1);
        apply_stimulus(1, 0, 0, 48'h0, 32'h0);

        // Coinciding pulses
        apply_stimulus(0, 1, 1, 48'd500, 32'd20);
        check("init_updt_time", {16'h0, t_time_abs_o}, 64'd500);
        check("init_updt_err", {63'h0, time_err_o}, 64'd0);
        check("init_updt_busy", {63'h0, updt_busy_o}, 64'd0);
        apply_stimulus(1, 1, 0, 48'd77, 32'h0);
        check("rst_init_time", {16'h0, t_time_abs_o}, 64'd0);
        check("rst_init_run", {63'h0, time_run_o}, 64'd0);

        // Async reset in the middle of an update
        apply_stimulus(0, 1, 0, 48'd40, 32'h0);
        apply_stimulus(0, 0, 1, 48'h0, 32'd3);
        async_reset();
        idle();

        // Sync pulse with period 8, first pulse 8 clocks after init
        sync_period_i = 32'd8;
        apply_stimulus(0, 1, 0, 48'd0, 32'h0);
        for (int k = 1; k <= 24; k++) begin
            idle();
`ifdef QNET_TIME_SYNC_EN
            exp_sync = (k % 8 == 0);
`else
            exp_sync = 0;
`endif
            check("sync_period8", {63'h0, net_sync_t01_o}, {63'h0, exp_sync});
        end

        // Randomized pulses against the model
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 99) < 2);
            i = ($urandom_range(0, 99) < 5);
            u = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 3) == 0)
                v = 48'hFFFF_FFFF_FFF0 + 48'($urandom_range(0, 15));
            else
                v = {16'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 0)
                o = $urandom;
            else
                o = 32'($urandom_range(0, 200)) - 32'd100;
            if ($urandom_range(0, 39) == 0)
                sync_period_i = 32'($urandom_range(0, 12));
            if ($urandom_range(0, 199) == 0)
                async_reset();
            else
                apply_stimulus(r, i, u, v, o);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
